// File: rtl/boxhead_pkg.sv
// Shared PS/2 receiver types and the HID keycodes that the game logic compares against.
// Holds the set-2 to HID translation table used by ps2_keycode_rx.
package boxhead_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   localparam logic [7:0] HID_W     = 8'h1A;
   localparam logic [7:0] HID_A     = 8'h04;
   localparam logic [7:0] HID_S     = 8'h16;
   localparam logic [7:0] HID_D     = 8'h07;
   localparam logic [7:0] HID_SPACE = 8'h2C;
   localparam logic [7:0] HID_ENTER = 8'h28;
   localparam logic [7:0] HID_UP    = 8'h52;
   localparam logic [7:0] HID_DOWN  = 8'h51;
   localparam logic [7:0] HID_LEFT  = 8'h50;
   localparam logic [7:0] HID_RIGHT = 8'h4F;

   typedef struct packed {
      logic       hit;
      logic [7:0] hid;
   } key_map_t;

   // Arrow keys only match with the E0 prefix; the bare codes are the keypad.
   function automatic key_map_t map_set2(input logic ext, input logic [7:0] code);
      key_map_t m;
      m.hit = 1'b1;
      m.hid = 8'h00;
      case ({ext, code})
         {1'b0, 8'h1D}: m.hid = HID_W;
         {1'b0, 8'h1C}: m.hid = HID_A;
         {1'b0, 8'h1B}: m.hid = HID_S;
         {1'b0, 8'h23}: m.hid = HID_D;
         {1'b0, 8'h29}: m.hid = HID_SPACE;
         {1'b0, 8'h5A}: m.hid = HID_ENTER;
         {1'b1, 8'h75}: m.hid = HID_UP;
         {1'b1, 8'h72}: m.hid = HID_DOWN;
         {1'b1, 8'h6B}: m.hid = HID_LEFT;
         {1'b1, 8'h74}: m.hid = HID_RIGHT;
         default:       m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect, frame FSM and
// inter-edge timeout. Strobes are combinational and valid in the stop-bit fall cycle.
module ps2_frame_rx
   import boxhead_pkg::*;
#(
   parameter int TIMEOUT_CYC = 10000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] rx_byte,
   output logic       byte_ok,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   sync_clk_prev;
   logic                   sync_clk;
   logic                   sync_dat;
   logic                   fall;
   logic                   timeout;
   logic                   stop_fall;
   logic                   par_ok;

   ps2_state_t       state;
   logic [2:0]       bit_cnt;
   logic [7:0]       sr;
   logic             par;
   logic [CNT_W-1:0] tmo_cnt;

   // NOTE: synchronisers reset to the idle-high pin level so leaving reset never fakes a fall.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         clk_sync      <= '1;
         dat_sync      <= '1;
         sync_clk_prev <= 1'b1;
      end else begin
         clk_sync      <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync      <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
         sync_clk_prev <= sync_clk;
      end
   end

   assign sync_clk  = clk_sync[SYNC_STAGES-1];
   assign sync_dat  = dat_sync[SYNC_STAGES-1];
   assign fall      = sync_clk_prev & ~sync_clk;
   // A fall landing on the expiry cycle takes priority over the timeout.
   assign timeout   = (state != IDLE) && (tmo_cnt == CNT_MAX) && !fall;
   assign stop_fall = fall && (state == STOP);
   assign par_ok    = ^{sr, par};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         sr      <= 8'h00;
         par     <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         if (fall || state == IDLE)
            tmo_cnt <= '0;
         else if (tmo_cnt != CNT_MAX)
            tmo_cnt <= tmo_cnt + 1'b1;

         if (timeout) begin
            state <= IDLE;
         end else if (fall) begin
            case (state)
               IDLE: if (!sync_dat) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
               DATA: begin
                  sr      <= {sync_dat, sr[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= sync_dat;
                  state <= STOP;
               end
               STOP:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rx_byte    = sr;
   assign byte_ok    = stop_fall & sync_dat & par_ok;
   assign parity_err = stop_fall & sync_dat & ~par_ok;
   assign frame_err  = (stop_fall & ~sync_dat) | timeout;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver producing the held-key HID keycode from scan code set 2.
// Tracks E0/F0 prefixes and applies the last-make-wins / matching-break-clears rule.
module ps2_keycode_rx
   import boxhead_pkg::*;
#(
   parameter int TIMEOUT_CYC = 10000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] keycode,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       parity_err,
   output logic       frame_err
);

   logic [7:0] rx_byte;
   logic       rx_ok;
   logic       rx_perr;
   logic       rx_ferr;
   logic       ext;
   logic       brk;
   key_map_t   key;

   ps2_frame_rx #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_frame (
      .Clk       (Clk),
      .Reset     (Reset),
      .PS2_CLK   (PS2_CLK),
      .PS2_DAT   (PS2_DAT),
      .rx_byte   (rx_byte),
      .byte_ok   (rx_ok),
      .parity_err(rx_perr),
      .frame_err (rx_ferr)
   );

   assign key = map_set2(ext, rx_byte);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         keycode    <= 8'h00;
         scan_code  <= 8'h00;
         scan_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
      end else begin
         scan_valid <= rx_ok;
         parity_err <= rx_perr;
         frame_err  <= rx_ferr;
         if (rx_perr || rx_ferr) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (rx_ok) begin
            scan_code <= rx_byte;
            if (rx_byte == PS2_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
               brk <= 1'b1;
            end else begin
               if (key.hit) begin
                  if (!brk)
                     keycode <= key.hid;
                  else if (key.hid == keycode)
                     keycode <= 8'h00;
               end
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: stimulus queues the expected event per PS/2 frame,
// a negedge monitor pops and compares whenever the DUT pulses an output strobe.
module tb_ps2_keycode_rx;

   localparam int TIMEOUT_CYC = 10000;
   localparam int SYNC_STAGES = 2;
   localparam int FAST_HALF   = 50;

   typedef enum int {EV_SCAN = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] code;
      logic [7:0] kc;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       PS2_CLK = 1'b1;
   logic       PS2_DAT = 1'b1;
   logic [7:0] keycode;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       parity_err;
   logic       frame_err;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_fall = 0;
   int   ferr_cyc = -1;
   int   ferr_seen = 0;
   exp_t sb[$];

   ps2_keycode_rx #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .PS2_CLK   (PS2_CLK),
      .PS2_DAT   (PS2_DAT),
      .keycode   (keycode),
      .scan_code (scan_code),
      .scan_valid(scan_valid),
      .parity_err(parity_err),
      .frame_err (frame_err)
   );

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: one expected event per output pulse, in order.
   exp_t     mon_e;
   ev_kind_t mon_kind;
   always @(negedge Clk) begin
      if (Reset && (scan_valid || parity_err || frame_err)) begin
         check("single_strobe", int'(scan_valid) + int'(parity_err) + int'(frame_err), 1);
         mon_kind = scan_valid ? EV_SCAN : (parity_err ? EV_PERR : EV_FERR);
         if (frame_err) begin
            ferr_cyc = cyc;
            ferr_seen++;
         end
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d code %0h, expected no event", mon_kind, scan_code);
         end else begin
            mon_e = sb.pop_front();
            check("event_kind", mon_kind, mon_e.kind);
            if (mon_e.kind == EV_SCAN) check("scan_code", scan_code, mon_e.code);
            check("keycode", keycode, mon_e.kc);
         end
      end
   end

   // Drives nbits of a frame (start, 8 data LSB first, odd parity, stop); flip corrupts parity.
   task automatic send_frame(input logic [7:0] b, input bit flip, input int nbits, input int half);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = bits[i];
         repeat (half) @(posedge Clk);
         #1 PS2_CLK = 1'b0;
         last_fall = cyc;
         repeat (half) @(posedge Clk);
         #1 PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
      repeat (half) @(posedge Clk);
      #1;
   endtask

   task automatic expect_ev(input ev_kind_t kind, input logic [7:0] code, input logic [7:0] kc);
      exp_t e;
      e.kind = kind;
      e.code = code;
      e.kc   = kc;
      sb.push_back(e);
   endtask

   task automatic good_frame(input logic [7:0] b, input logic [7:0] kc, input int half);
      expect_ev(EV_SCAN, b, kc);
      send_frame(b, 1'b0, 11, half);
   endtask

   task automatic check_all_zero();
      check("rst_keycode", keycode, 8'h00);
      check("rst_scan_code", scan_code, 8'h00);
      check("rst_scan_valid", scan_valid, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
   endtask

   int ferr_before;

   initial begin
      repeat (5) @(posedge Clk);
      #1 check_all_zero();
      Reset = 1'b1;
      repeat (5) @(posedge Clk);
      #1;

      // 40 us bit period at 50 MHz: 1000 cycles per half bit.
      good_frame(8'h1D, 8'h1A, 1000);

      good_frame(8'h1C, 8'h04, FAST_HALF);
      good_frame(8'hF0, 8'h04, FAST_HALF);
      good_frame(8'h1D, 8'h04, FAST_HALF);   // break of W, A still held
      good_frame(8'hF0, 8'h04, FAST_HALF);
      good_frame(8'h1C, 8'h00, FAST_HALF);

      good_frame(8'hE0, 8'h00, FAST_HALF);
      good_frame(8'h75, 8'h52, FAST_HALF);   // Up
      good_frame(8'h75, 8'h52, FAST_HALF);   // keypad 8: unmapped
      good_frame(8'hE0, 8'h52, FAST_HALF);
      good_frame(8'hF0, 8'h52, FAST_HALF);
      good_frame(8'h75, 8'h00, FAST_HALF);

      expect_ev(EV_PERR, 8'h00, 8'h00);
      send_frame(8'h23, 1'b1, 11, FAST_HALF);
      good_frame(8'h23, 8'h07, FAST_HALF);

      // Timeout: start plus 4 data bits, then the clock stops.
      ferr_before = ferr_seen;
      expect_ev(EV_FERR, 8'h00, 8'h07);
      send_frame(8'h1B, 1'b0, 5, FAST_HALF);
      for (int i = 0; i < TIMEOUT_CYC + 200 && ferr_seen == ferr_before; i++) @(posedge Clk);
      #1;
      check("timeout_seen", ferr_seen - ferr_before, 1);
      // Pin-to-fall latency is SYNC_STAGES+1 cycles; frame_err follows TIMEOUT_CYC cycles later.
      check("timeout_delay", ferr_cyc - last_fall, TIMEOUT_CYC + SYNC_STAGES + 1);
      good_frame(8'h1B, 8'h16, FAST_HALF);

      // Break prefix, then reset in the middle of the next frame.
      good_frame(8'hF0, 8'h16, FAST_HALF);
      send_frame(8'h29, 1'b0, 4, FAST_HALF);
      Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1 check_all_zero();
      Reset = 1'b1;
      repeat (10) @(posedge Clk);
      #1;
      good_frame(8'h29, 8'h2C, FAST_HALF);

      repeat (20) @(posedge Clk);
      #1 check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
